flag_cond_stack: RTL

FLAG_COND_STACK -- requirements
Module: flag_cond_stack

---
 rtl/flag_cond_stack_if.sv | 19 +
 rtl/flag_cond_stack.sv | 78 +++++++
 2 files changed

// File: rtl/flag_cond_stack_if.sv
// flag_cond_stack_if: flag inputs, evaluation/stack requests and results of flag_cond_stack.
interface flag_cond_stack_if;
  logic NEG, ZER, CAR, OVERF, MODE;
  logic [3:0] cond;
  logic cond_valid, push, pop, err_clr;
  logic take, take_valid;
  logic [4:0] restore_flags;
  logic restore_valid;
  logic [3:0] depth;
  logic ovf_err, unf_err;
  modport master (
    output NEG, ZER, CAR, OVERF, MODE, cond, cond_valid, push, pop, err_clr,
    input  take, take_valid, restore_flags, restore_valid, depth, ovf_err, unf_err
  );
  modport slave (
    input  NEG, ZER, CAR, OVERF, MODE, cond, cond_valid, push, pop, err_clr,
    output take, take_valid, restore_flags, restore_valid, depth, ovf_err, unf_err
  );
endinterface

// File: rtl/flag_cond_stack.sv
// flag_cond_stack: registered condition-code evaluator plus a flag-context stack built only when FLAG_STACK_EN is defined.
module flag_cond_stack #(
  parameter int DEPTH = 4
) (
  input logic clock,
  input logic reset,
  flag_cond_stack_if.slave bus
);
  logic take_q, take_d, take_valid_q, nv;
  logic [15:0] hit;
  always_comb begin
    nv = bus.NEG ^ bus.OVERF;
    hit = {1'b0, 1'b1, bus.ZER | nv, !bus.ZER & !nv, nv, !nv, !bus.CAR | bus.ZER, bus.CAR & !bus.ZER,
           !bus.OVERF, bus.OVERF, !bus.NEG, bus.NEG, !bus.CAR, bus.CAR, !bus.ZER, bus.ZER};
    take_d = bus.cond_valid ? hit[bus.cond] : take_q;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      take_q <= 1'b0;
      take_valid_q <= 1'b0;
    end else begin
      take_q <= take_d;
      take_valid_q <= bus.cond_valid;
    end
  assign bus.take = take_q;
  assign bus.take_valid = take_valid_q;
`ifdef FLAG_STACK_EN
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic [4:0] stk_q [DEPTH];
  logic [4:0] live, restore_q, restore_d;
  logic [3:0] depth_q, depth_d;
  logic restore_valid_q, ovf_q, ovf_d, unf_q, unf_d, do_pop, do_push, empty, full;
  logic [AW-1:0] top, wr;
  always_comb begin
    live = {bus.NEG, bus.ZER, bus.CAR, bus.OVERF, bus.MODE};
    empty = depth_q == 4'd0;
    full = depth_q == 4'(DEPTH);
    do_pop = bus.pop & !empty;
    // a pop in the same cycle frees the top slot, so push+pop on a full stack is a swap
    do_push = bus.push & (!full | do_pop);
    top = AW'(depth_q - 4'd1);
    wr = do_pop ? top : AW'(depth_q);
    restore_d = do_pop ? stk_q[top] : restore_q;
    depth_d = depth_q + {3'd0, do_push & !do_pop} - {3'd0, do_pop & !do_push};
    ovf_d = (bus.push & full & !bus.pop) | (ovf_q & !bus.err_clr);
    unf_d = (bus.pop & empty) | (unf_q & !bus.err_clr);
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stk_q[i] <= '0;
      restore_q <= '0;
      restore_valid_q <= 1'b0;
      depth_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (do_push) stk_q[wr] <= live;
      restore_q <= restore_d;
      restore_valid_q <= do_pop;
      depth_q <= depth_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  assign bus.restore_flags = restore_q;
  assign bus.restore_valid = restore_valid_q;
  assign bus.depth = depth_q;
  assign bus.ovf_err = ovf_q;
  assign bus.unf_err = unf_q;
`else
  logic unused_ok;
  assign unused_ok = ^{bus.push, bus.pop, bus.err_clr, bus.MODE};
  assign bus.restore_flags = '0;
  assign bus.restore_valid = 1'b0;
  assign bus.depth = '0;
  assign bus.ovf_err = 1'b0;
  assign bus.unf_err = 1'b0;
`endif
endmodule
